// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver (16x oversampled) feeding a FWFT FIFO     |
// | Revision     : 1.0                                                         |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              push;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              pop, push_ok;

  // rx is asynchronous to clk_50m; reset to the idle-high line level
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (clken) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = 4'd0;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              cnt_d   = 4'd0;
              bit_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            shift_d = {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'd15) begin
            cnt_d = 4'd0;
            if (rx_s_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HI;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_WAIT_HI: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  always_comb begin
    pop       = rd_en && !empty_q;
    push_ok   = push && (!full_q || pop);
    overrun_d = push && !push_ok;
    wr_ptr_d  = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
    end
  end

  // Storage is cleared on reset so dout reads zero out of reset
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign dout      = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_fifo : randomized self-checking bench for uart_rx_fifo          |
// | Revision        : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b1;
  logic       clken   = 1'b0;
  logic       rx      = 1'b1;
  logic       rd_en   = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .clken    (clken),
    .rx       (rx),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame outcome announced by the driver on the mid-stop-bit tick
  logic       ev_valid = 1'b0;
  logic       ev_ok    = 1'b0;
  logic [7:0] ev_byte  = 8'd0;
  int         rd_mode  = 0;

  byte unsigned mq[$];
  logic exp_fe = 1'b0, exp_ov = 1'b0;
  logic m_pop, m_acc;
  int   seen_fe = 0, seen_ov = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue with accept/drop rules applied per clock
  initial forever begin
    @(posedge clk_50m or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      exp_fe = 1'b0;
      exp_ov = 1'b0;
    end else begin
      m_pop  = rd_en && (mq.size() != 0);
      m_acc  = ev_valid && ev_ok && ((mq.size() < DEPTH) || m_pop);
      exp_ov = ev_valid && ev_ok && !m_acc;
      exp_fe = ev_valid && !ev_ok;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(ev_byte);
    end
  end

  initial forever begin
    @(negedge clk_50m);
    if (rst_n) begin
      check("empty", empty, int'(mq.size() == 0));
      check("full", full, int'(mq.size() == DEPTH));
      if (mq.size() != 0) check("dout", dout, mq[0]);
      check("frame_err", frame_err, exp_fe);
      check("overrun", overrun, exp_ov);
      if (frame_err) seen_fe++;
      if (overrun)   seen_ov++;
    end
  end

  task automatic step(input logic ce, input logic evv, input logic evok,
                      input logic [7:0] evb, input logic frd);
    @(negedge clk_50m);
    clken    = ce;
    ev_valid = evv;
    ev_ok    = evok;
    ev_byte  = evb;
    rd_en    = frd || (rd_mode == 1 && $urandom_range(0, 3) == 0);
  endtask

  // One 16x tick: rx settles through the synchronizer before clken fires
  task automatic tick(input logic v, input logic evv, input logic evok,
                      input logic [7:0] evb, input logic frd);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rx = v;
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, evv, evok, evb, frd);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic low(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Bit k of the frame spans ticks 16k..16k+15; the receiver samples at 16k+8
  task automatic send_frame(input logic [7:0] b, input logic stopbit,
                            input int abort_at, input logic pop_at_push);
    logic v;
    for (int i = 0; i < 160; i++) begin
      if (abort_at >= 0 && i == abort_at) return;
      if (i < 16)       v = 1'b0;
      else if (i < 144) v = b[(i-16)/16];
      else              v = stopbit;
      tick(v, i == 152, stopbit, b, (i == 152) && pop_at_push);
    end
  endtask

  task automatic read_expect(input logic [7:0] e);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("read_empty", empty, 0);
    check("read_data", dout, e);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    int fe_base, ov_base, guard;
    logic [7:0] rb;
    logic sb, pp;

    #1 rst_n = 1'b0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", dout, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    idle(8);

    send_frame(8'hA5, 1'b1, -1, 1'b0);
    idle(4);
    check("a5_empty", empty, 0);
    check("a5_dout", dout, 8'hA5);
    read_expect(8'hA5);
    check("a5_empty_after", empty, 1);
    check("a5_no_pulses", seen_fe + seen_ov, 0);

    fe_base = seen_fe; ov_base = seen_ov;
    low(4);
    idle(12);
    check("glitch_empty", empty, 1);
    check("glitch_fe", seen_fe - fe_base, 0);
    check("glitch_ov", seen_ov - ov_base, 0);

    fe_base = seen_fe;
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    low(40);
    check("break_fe_once", seen_fe - fe_base, 1);
    check("break_empty", empty, 1);
    idle(4);
    send_frame(8'h81, 1'b1, -1, 1'b0);
    idle(2);
    read_expect(8'h81);
    check("break_fe_total", seen_fe - fe_base, 1);

    ov_base = seen_ov;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, -1, 1'b0);
      if (k == 4) check("ovr_full_at4", full, 1);
    end
    idle(2);
    check("ovr_once", seen_ov - ov_base, 1);
    for (int k = 1; k <= 4; k++) read_expect(8'(k));
    check("ovr_drained", empty, 1);

    ov_base = seen_ov;
    for (int k = 0; k < 4; k++) send_frame(8'h10 + 8'(k), 1'b1, -1, 1'b0);
    send_frame(8'h77, 1'b1, -1, 1'b1);
    idle(2);
    check("simul_no_ovr", seen_ov - ov_base, 0);
    check("simul_full", full, 1);
    read_expect(8'h11);
    read_expect(8'h12);
    read_expect(8'h13);
    read_expect(8'h77);
    check("simul_empty", empty, 1);

    send_frame(8'h21, 1'b1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    send_frame(8'h99, 1'b1, 40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rx = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_dout", dout, 0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h5A, 1'b1, -1, 1'b0);
    idle(2);
    check("post_rst_dout", dout, 8'h5A);
    read_expect(8'h5A);
    check("post_rst_only", empty, 1);

    rd_mode = 1;
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      pp = 1'($urandom_range(0, 1));
      send_frame(rb, sb, -1, pp);
      if (!sb) begin
        low($urandom_range(0, 20));
        idle(2);
      end
    end
    guard = 0;
    while (mq.size() != 0 && guard < 200) begin
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check("final_drained", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
